// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the streaming Sobel filter.
//   sobel_state_t  - frame sequencer state encoding
//   SOBEL_K_*      - Sobel kernel weights (outer taps and centre tap)
//   FLUSH_CYCLES   - cycles spent draining the output pipeline after the last pixel
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sobel_state_t;

  // Each derivative is a [1 2 1] smoothing across a [-1 0 +1] difference.
  localparam int SOBEL_K_OUTER  = 1;
  localparam int SOBEL_K_CENTRE = 2;

  // Matches the window -> result pipeline depth so the last output has left
  // before frame_done is raised.
  localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image row of delay, built as a write-enabled shift register.
//   clk   - clock
//   we    - shift din in (one accepted pixel)
//   din   - pixel entering the row delay
//   dout  - pixel written DEPTH shifts ago (registered tail, valid before the shift)
// Contents are not reset; a new frame fills the row before anything reads it.
module sobel_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: raster-order streaming 3x3 Sobel filter.
//   clk, reset           - single clock, synchronous active-high reset
//   start, thr           - begin a frame; thr captured with the accepted start
//   in_valid/in_ready    - pixel handshake, in_ready only while streaming
//   in_pixel             - raster-order input pixel
//   out_valid            - one-cycle qualifier for out_pixel/out_addr
//   out_pixel            - saturated |Gx|+|Gy| (MODE 0) or binary edge (MODE 1)
//   out_addr             - linear address of the window centre
//   frame_done           - one-cycle pulse after the last output of a frame
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | accepting pixels, in_ready high
// FLUSH  | last pixel taken, draining the output pipeline
// DONE   | frame_done pulse
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int MODE   = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [DATA_W-1:0]                   thr,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_pixel,
  output logic                                out_valid,
  output logic [DATA_W-1:0]                   out_pixel,
  output logic [$clog2(IMG_W*IMG_H)-1:0]      out_addr,
  output logic                                frame_done
);

  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(N_PIX);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int GW     = DATA_W + 3;
  localparam int MW     = DATA_W + 4;

  localparam logic signed [GW-1:0] K_O = GW'(SOBEL_K_OUTER);
  localparam logic signed [GW-1:0] K_C = GW'(SOBEL_K_CENTRE);

  sobel_state_t      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [1:0]        flush_q, flush_d;

  // win_q[row][col]: row 0 oldest line, col 2 newest pixel.
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic              win_v_q, win_v_d;
  logic [ADDR_W-1:0] win_addr_q, win_addr_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic              accept;
  logic [DATA_W-1:0] lb0_dout, lb1_dout;

  assign accept = in_valid && (state_q == ST_RUN);

  sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .din  (in_pixel),
    .dout (lb0_dout)
  );

  sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    thr_d      = thr_q;
    flush_d    = flush_q;
    win_d      = win_q;
    win_v_d    = 1'b0;
    win_addr_d = win_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          thr_d   = thr;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          idx_d = idx_q + ADDR_W'(1);
          if (col_q == COL_W'(IMG_W-1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (idx_q == ADDR_W'(N_PIX-1)) begin
            state_d = ST_FLUSH;
            flush_d = 2'(FLUSH_CYCLES-1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == 2'd0) begin
          state_d = ST_DONE;
        end else begin
          flush_d = flush_q - 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_dout;
      win_d[1][2] = lb0_dout;
      win_d[2][2] = in_pixel;
      // The pixel at (r,c) completes the window centred on (r-1,c-1).
      win_v_d    = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      win_addr_d = idx_q - ADDR_W'(IMG_W+1);
    end
  end

  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [MW-1:0]        mag;
  logic [DATA_W-1:0]    result;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p[i][j] = $signed({{3{1'b0}}, win_q[i][j]});
      end
    end
    gx = (K_O * p[0][2] + K_C * p[1][2] + K_O * p[2][2])
       - (K_O * p[0][0] + K_C * p[1][0] + K_O * p[2][0]);
    gy = (K_O * p[2][0] + K_C * p[2][1] + K_O * p[2][2])
       - (K_O * p[0][0] + K_C * p[0][1] + K_O * p[0][2]);
    ax  = gx[GW-1] ? -gx : gx;
    ay  = gy[GW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};

    if (MODE == 1) begin
      result = (mag >= {{(MW-DATA_W){1'b0}}, thr_q}) ? '1 : '0;
    end else begin
      result = (|mag[MW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
    end

    out_valid_d = win_v_q;
    out_pixel_d = out_pixel_q;
    out_addr_d  = out_addr_q;
    if (win_v_q) begin
      out_pixel_d = result;
      out_addr_d  = win_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      thr_q       <= '0;
      flush_q     <= '0;
      win_v_q     <= 1'b0;
      win_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      thr_q       <= thr_d;
      flush_q     <= flush_d;
      win_v_q     <= win_v_d;
      win_addr_q  <= win_addr_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // Window data needs no reset: win_v_q gates every use of it.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign in_ready   = (state_q == ST_RUN);
  assign frame_done = (state_q == ST_DONE);
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] thr;
  logic       in_valid;
  logic [7:0] in_pixel;

  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [7:0] out_pixel0, out_pixel1;
  logic [5:0] out_addr0, out_addr1;
  logic       frame_done0, frame_done1;

  always #5 clk = ~clk;

  sobel_stream #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_pixel(in_pixel),
    .out_valid(out_valid0), .out_pixel(out_pixel0), .out_addr(out_addr0),
    .frame_done(frame_done0)
  );

  sobel_stream #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pixel(in_pixel),
    .out_valid(out_valid1), .out_pixel(out_pixel1), .out_addr(out_addr1),
    .frame_done(frame_done1)
  );

  typedef struct {
    int addr;
    int pix;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int outs0 = 0;
  int outs1 = 0;
  int fd0 = 0;
  int fd1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per DUT output.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid0) begin
      outs0++;
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL m0_unexpected: got addr %0d expected no output", out_addr0);
      end else begin
        e = q0.pop_front();
        chk("m0_addr", int'(out_addr0), e.addr);
        chk("m0_pix", int'(out_pixel0), e.pix);
        chk("m0_latency", cyc, e.cyc);
      end
    end
    if (out_valid1) begin
      outs1++;
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL m1_unexpected: got addr %0d expected no output", out_addr1);
      end else begin
        e = q1.pop_front();
        chk("m1_addr", int'(out_addr1), e.addr);
        chk("m1_pix", int'(out_pixel1), e.pix);
        chk("m1_latency", cyc, e.cyc);
      end
    end
    if (frame_done0) fd0++;
    if (frame_done1) fd1++;
  end

  // kind 0: flat frame of value h; kind 1: vertical step, cols 4..7 = h.
  function automatic int pix(input int kind, input int h, input int c);
    if (kind == 0) return h;
    return (c >= 4) ? h : 0;
  endfunction

  // Hand-derived: a step of height h gives |Gx| = 4h at centre cols 3 and 4.
  function automatic int exp_mag(input int kind, input int h, input int cc);
    if (kind == 1 && (cc == 3 || cc == 4)) return 4 * h;
    return 0;
  endfunction

  task automatic do_start(input int t);
    @(posedge clk); #1;
    start = 1'b1;
    thr = 8'(t);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input string tag, input int kind, input int h, input int t,
                            input bit bub, input int abort_at, input bit mid_start);
    int n;
    int r;
    int c;
    int m;
    int k;
    int stall;
    bit rdy;
    exp_t e;
    outs0 = 0;
    outs1 = 0;
    do_start(t);
    n = 0;
    stall = 0;
    while (n < 64) begin
      if (bub && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      r = n / 8;
      c = n % 8;
      in_valid = 1'b1;
      in_pixel = 8'(pix(kind, h, c));
      if (mid_start && n == 20) begin
        start = 1'b1;
        thr = 8'd0;
      end
      rdy = in_ready0;
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy) begin
        if (r >= 2 && c >= 2) begin
          m = exp_mag(kind, h, c - 1);
          e.addr = (r - 1) * 8 + (c - 1);
          e.cyc = (cyc - 1) + 2;
          e.pix = (m > 255) ? 255 : m;
          q0.push_back(e);
          e.pix = (m >= t) ? 255 : 0;
          q1.push_back(e);
        end
        n++;
        if (n == abort_at) break;
      end else begin
        stall++;
        if (stall > 50) begin
          chk({tag, "_in_ready_stall"}, 0, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;

    if (abort_at != 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_rst_in_ready"}, int'(in_ready0), 0);
      chk({tag, "_rst_out_valid0"}, int'(out_valid0), 0);
      chk({tag, "_rst_out_valid1"}, int'(out_valid1), 0);
      chk({tag, "_rst_out_addr"}, int'(out_addr0), 0);
      chk({tag, "_rst_out_pixel"}, int'(out_pixel0), 0);
      q0.delete();
      q1.delete();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_post_rst_quiet"}, int'(out_valid0 | out_valid1 | frame_done0), 0);
    end else begin
      k = 0;
      while (!frame_done0 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      chk({tag, "_frame_done_seen"}, int'(frame_done0), 1);
      chk({tag, "_frame_done_both"}, int'(frame_done1), 1);
      chk({tag, "_q0_empty_at_done"}, q0.size(), 0);
      chk({tag, "_q1_empty_at_done"}, q1.size(), 0);
      chk({tag, "_outs0"}, outs0, 36);
      chk({tag, "_outs1"}, outs1, 36);
      @(posedge clk); #1;
      chk({tag, "_frame_done_pulse"}, int'(frame_done0), 0);
      chk({tag, "_idle_in_ready"}, int'(in_ready0), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    thr = 8'd0;
    in_valid = 1'b0;
    in_pixel = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready0), 0);
    chk("reset_out_valid", int'(out_valid0), 0);
    chk("reset_out_pixel", int'(out_pixel0), 0);
    chk("reset_out_addr", int'(out_addr0), 0);
    chk("reset_frame_done", int'(frame_done0), 0);
    chk("reset_m1_out_valid", int'(out_valid1), 0);
    reset = 1'b0;

    send_frame("flat",       0, 100, 128, 1'b0, 0,  1'b0);
    send_frame("step255",    1, 255, 128, 1'b0, 0,  1'b0);
    send_frame("step20",     1, 20,  128, 1'b0, 0,  1'b0);
    send_frame("step40",     1, 40,  128, 1'b0, 0,  1'b0);
    send_frame("step255_bub",1, 255, 128, 1'b1, 0,  1'b0);
    send_frame("abort",      0, 100, 128, 1'b0, 30, 1'b0);
    send_frame("flat_again", 0, 100, 128, 1'b0, 0,  1'b0);
    send_frame("mid_start",  0, 100, 128, 1'b0, 0,  1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("total_frame_done0", fd0, 7);
    chk("total_frame_done1", fd1, 7);
    chk("leftover_q0", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
